rst_sequencer: RTL and testbench

Control-side counterpart of the delayed-reset generator. On request it drives the generator's reset-request input for a programmable number of cycles, then watches the generator's reset status: low means the reset was taken, high again means it was released. It reports completion or timeout to the tester FSM. It sits between the test-control FSM and the reset generator; one sequence is in flight at a time, plus a single pending request.

---
 rtl/rst_sequencer_if.sv | 33 +++
 rtl/rst_sequencer.sv | 142 ++++++++++++++
 tb/tb_rst_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rst_sequencer_if.sv
// Handshake bundle between the test-control FSM, the reset sequencer and the
// reset generator status line.
interface rst_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             in_req;
    logic             in_rst_stat;
    logic             out_fsm_rst;
    logic             out_busy;
    logic             out_done;
    logic             out_timeout;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_req,
        output in_rst_stat,
        input  out_fsm_rst,
        input  out_busy,
        input  out_done,
        input  out_timeout,
        input  out_count
    );

    modport slave (
        input  in_req,
        input  in_rst_stat,
        output out_fsm_rst,
        output out_busy,
        output out_done,
        output out_timeout,
        output out_count
    );
endinterface

// File: rtl/rst_sequencer.sv
// Drives a timed reset request into the reset generator, then watches its
// status for take and release, reporting done or timeout to the tester FSM.
module rst_sequencer #(
    parameter int PULSE_LEN = 2,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 8
) (
    input  logic          in_clk,
    input  logic          in_rst_n,
    rst_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ASSERT    = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    localparam logic [7:0]  PULSE_INIT = 8'(PULSE_LEN);
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

    state_t           r_state;
    logic             r_pending;
    logic [7:0]       r_pulse_cnt;
    logic [15:0]      r_timer;
    logic             r_fsm_rst;
    logic             r_done;
    logic             r_timeout;
    logic [CNT_W-1:0] r_count;

    state_t           w_state_nxt;
    logic             w_pending_nxt;
    logic [7:0]       w_pulse_nxt;
    logic [15:0]      w_timer_nxt;
    logic             w_fsm_rst_nxt;
    logic             w_done_nxt;
    logic             w_timeout_nxt;
    logic [CNT_W-1:0] w_count_nxt;

    // Next-state, pending-flag, counter and registered-output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_pulse_nxt   = r_pulse_cnt;
        w_timer_nxt   = r_timer;
        w_done_nxt    = 1'b0;
        w_timeout_nxt = 1'b0;
        w_count_nxt   = r_count;

        // One-deep queue: a request seen while busy is remembered, extras merge
        if ((r_state != ST_IDLE) && bus.in_req) begin
            w_pending_nxt = 1'b1;
        end else begin
            w_pending_nxt = r_pending;
        end

        case (r_state)
            ST_IDLE: begin
                if (bus.in_req || r_pending) begin
                    w_pending_nxt = 1'b0;
                    w_pulse_nxt   = PULSE_INIT;
                    w_state_nxt   = ST_ASSERT;
                end else begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (r_pulse_cnt <= 8'd1) begin
                    w_pulse_nxt = 8'd0;
                    w_timer_nxt = 16'd0;
                    w_state_nxt = ST_WAIT_LOW;
                end else begin
                    w_pulse_nxt = r_pulse_cnt - 8'd1;
                end
            end
            ST_WAIT_LOW: begin
                // Status check wins over the timeout on the same cycle
                if (!bus.in_rst_stat) begin
                    w_timer_nxt = 16'd0;
                    w_state_nxt = ST_WAIT_HIGH;
                end else if (r_timer == TMO_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            ST_WAIT_HIGH: begin
                if (bus.in_rst_stat) begin
                    w_done_nxt  = 1'b1;
                    w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    w_state_nxt = ST_DONE;
                end else if (r_timer == TMO_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_fsm_rst_nxt = (w_state_nxt == ST_ASSERT);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            r_state     <= ST_IDLE;
            r_pending   <= 1'b0;
            r_pulse_cnt <= 8'd0;
            r_timer     <= 16'd0;
            r_fsm_rst   <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_pulse_cnt <= w_pulse_nxt;
            r_timer     <= w_timer_nxt;
            r_fsm_rst   <= w_fsm_rst_nxt;
            r_done      <= w_done_nxt;
            r_timeout   <= w_timeout_nxt;
            r_count     <= w_count_nxt;
        end
    end

    assign bus.out_fsm_rst = r_fsm_rst;
    assign bus.out_busy    = (r_state != ST_IDLE);
    assign bus.out_done    = r_done;
    assign bus.out_timeout = r_timeout;
    assign bus.out_count   = r_count;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with a behavioural reset-generator model
// (status falls 2 cycles after the request drops, rises 4 cycles later).
module tb_rst_sequencer;

    logic in_clk = 1'b0;
    logic in_rst_n;

    rst_sequencer_if #(.CNT_W(2)) sif();

    rst_sequencer #(
        .PULSE_LEN (2),
        .TIMEOUT   (16),
        .CNT_W     (2)
    ) dut (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .bus      (sif.slave)
    );

    always #5 in_clk = ~in_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int c0 = 0;
    int n_done, n_tmo, n_hi, n_busy;
    int n_both = 0;
    int done_cyc, tmo_cyc, idle_cyc;
    logic prev_busy = 1'b0;
    logic prev_fsm  = 1'b0;
    logic gen_en    = 1'b1;
    logic stuck_low = 1'b0;
    int   gen_t     = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clr();
        n_done   = 0;
        n_tmo    = 0;
        n_hi     = 0;
        n_busy   = 0;
        done_cyc = -1000;
        tmo_cyc  = -1000;
        idle_cyc = -1000;
    endtask

    // One clock: sample just after the edge, log events, advance the generator model
    task automatic tick();
        @(posedge in_clk);
        #1;
        cyc++;
        if (sif.out_done) begin n_done++; done_cyc = cyc; end
        if (sif.out_timeout) begin n_tmo++; tmo_cyc = cyc; end
        if (sif.out_done && sif.out_timeout) n_both++;
        if (sif.out_fsm_rst) n_hi++;
        if (sif.out_busy) n_busy++;
        if (prev_busy && !sif.out_busy) idle_cyc = cyc;
        prev_busy = sif.out_busy;
        if (gen_en && prev_fsm && !sif.out_fsm_rst) gen_t = 0;
        else if (gen_t >= 0) gen_t++;
        if (gen_t == 2) sif.in_rst_stat = 1'b0;
        if (gen_t == 6) begin
            if (!stuck_low) sif.in_rst_stat = 1'b1;
            gen_t = -1;
        end
        prev_fsm = sif.out_fsm_rst;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_req();
        sif.in_req = 1'b1;
        tick();
        c0 = cyc;
        sif.in_req = 1'b0;
    endtask

    task automatic do_reset();
        in_rst_n        = 1'b0;
        sif.in_req      = 1'b0;
        sif.in_rst_stat = 1'b1;
        stuck_low       = 1'b0;
        gen_t           = -1;
        tick();
        in_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_rst_n        = 1'b0;
        sif.in_req      = 1'b0;
        sif.in_rst_stat = 1'b1;
        clr();
        ticks(2);
        chk("rst_fsm_rst", sif.out_fsm_rst, 0);
        chk("rst_busy",    sif.out_busy,    0);
        chk("rst_done",    sif.out_done,    0);
        chk("rst_timeout", sif.out_timeout, 0);
        chk("rst_count",   sif.out_count,   0);
        in_rst_n = 1'b1;
        tick();

        // Basic sequence
        clr();
        pulse_req();
        chk("lat_fsm_rst", sif.out_fsm_rst, 1);
        chk("lat_busy",    sif.out_busy,    1);
        ticks(15);
        chk("basic_hi",    n_hi, 2);
        chk("basic_done",  n_done, 1);
        chk("basic_tmo",   n_tmo, 0);
        chk("basic_count", sif.out_count, 1);
        chk("basic_len",   done_cyc - c0, 9);
        chk("basic_idle",  idle_cyc - done_cyc, 1);

        // Status stuck high: timeout out of WAIT_LOW
        gen_en = 1'b0;
        clr();
        pulse_req();
        ticks(25);
        chk("sh_tmo_at", tmo_cyc - c0, 18);
        chk("sh_tmo",    n_tmo, 1);
        chk("sh_done",   n_done, 0);
        chk("sh_busy",   n_busy, 18);
        chk("sh_count",  sif.out_count, 1);

        // Status stuck low after take: timeout out of WAIT_HIGH, then recovery
        gen_en    = 1'b1;
        stuck_low = 1'b1;
        clr();
        pulse_req();
        ticks(30);
        chk("sl_tmo_at", tmo_cyc - c0, 21);
        chk("sl_tmo",    n_tmo, 1);
        chk("sl_done",   n_done, 0);
        chk("sl_count",  sif.out_count, 1);
        stuck_low       = 1'b0;
        sif.in_rst_stat = 1'b1;
        clr();
        pulse_req();
        ticks(15);
        chk("rec_done",  n_done, 1);
        chk("rec_count", sif.out_count, 2);

        // Status falls exactly on the last WAIT_LOW cycle: success wins
        gen_en = 1'b0;
        clr();
        pulse_req();
        ticks(17);
        sif.in_rst_stat = 1'b0;
        tick();
        sif.in_rst_stat = 1'b1;
        ticks(5);
        chk("pri_tmo",     n_tmo, 0);
        chk("pri_done",    n_done, 1);
        chk("pri_done_at", done_cyc - c0, 19);
        chk("pri_count",   sif.out_count, 3);
        gen_en = 1'b1;

        // Back-to-back: held request queues one, a later one is dropped
        do_reset();
        clr();
        sif.in_req = 1'b1;
        tick();
        c0 = cyc;
        ticks(2);
        sif.in_req = 1'b0;
        ticks(2);
        sif.in_req = 1'b1;
        tick();
        sif.in_req = 1'b0;
        ticks(25);
        chk("b2b_done",    n_done, 2);
        chk("b2b_hi",      n_hi, 4);
        chk("b2b_tmo",     n_tmo, 0);
        chk("b2b_done_at", done_cyc - c0, 20);
        chk("b2b_count",   sif.out_count, 2);

        // Counter wrap with a 2-bit counter
        do_reset();
        clr();
        for (int k = 1; k <= 5; k++) begin
            pulse_req();
            ticks(15);
            chk("wrap_count", sif.out_count, k % 4);
        end
        chk("wrap_done", n_done, 5);

        // Reset while in WAIT_HIGH with a request pending
        clr();
        pulse_req();
        ticks(6);
        chk("mid_busy", sif.out_busy, 1);
        sif.in_req = 1'b1;
        tick();
        sif.in_req = 1'b0;
        in_rst_n   = 1'b0;
        tick();
        chk("mid_fsm_rst", sif.out_fsm_rst, 0);
        chk("mid_busy0",   sif.out_busy,    0);
        chk("mid_done0",   sif.out_done,    0);
        chk("mid_tmo0",    sif.out_timeout, 0);
        chk("mid_count",   sif.out_count,   0);
        in_rst_n = 1'b1;
        n_busy = 0;
        ticks(30);
        chk("mid_done",    n_done, 0);
        chk("mid_tmo",     n_tmo, 0);
        chk("mid_pending", n_busy, 0);

        chk("excl", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
